// File: rtl/ball_object.sv
// Pinball ball object: frame-rate physics (walls, collision bounce, gravity) and a
// registered per-pixel painter feeding one input of the layer priority mux.
module ball_object #(
    parameter int         BALL_SIZE  = 16,
    parameter logic [7:0] BALL_COLOR = 8'hE0,
    parameter int         SCREEN_W   = 640,
    parameter int         SCREEN_H   = 480,
    parameter int         INIT_X     = 320,
    parameter int         INIT_Y     = 100,
    parameter int         INIT_VX    = 2,
    parameter int         INIT_VY    = 0,
    parameter int         GRAV_DIV   = 4,
    parameter int         VMAX       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        collision,
    input  logic        launch,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        ball_lost
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVING,
        S_LOST
    } state_t;

    localparam int                      CNT_W    = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(GRAV_DIV - 1);
    localparam logic signed [11:0]      X_MAX    = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0]      Y_LIM    = 12'(SCREEN_H);
    localparam logic signed [11:0]      SIZE_S   = 12'(BALL_SIZE);
    localparam logic signed [11:0]      X_INIT   = 12'(INIT_X);
    localparam logic signed [11:0]      Y_INIT   = 12'(INIT_Y);
    localparam logic signed [5:0]       VX_INIT  = 6'(INIT_VX);
    localparam logic signed [5:0]       VY_INIT  = 6'(INIT_VY);
    localparam logic signed [5:0]       V_MAX    = 6'(VMAX);

    state_t                  r_state, w_state_next;
    logic signed [11:0]      r_x, r_y, w_x_next, w_y_next;
    logic signed [11:0]      w_nx, w_ny, w_px, w_py;
    logic signed [5:0]       r_vx, r_vy, w_vx_next, w_vy_next;
    logic signed [5:0]       w_vy1, w_vy_eff, w_vy_inc;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic                    r_launch_l, r_col_l;
    logic                    w_launch, w_col, w_launch_l_next, w_col_l_next;
    logic                    w_lost_next, w_inside;
    logic                    r_draw, r_lost;
    logic [7:0]              r_rgb;

    // A pulse coinciding with SOF counts for that SOF, so the latches are OR-ed with the live input.
    assign w_launch        = r_launch_l | (launch & (r_state == S_IDLE));
    assign w_col           = r_col_l | (collision & (r_state == S_MOVING));
    assign w_launch_l_next = startOfFrame ? 1'b0 : w_launch;
    assign w_col_l_next    = startOfFrame ? 1'b0 : w_col;

    assign w_vy1 = (w_col && (r_vy > 6'sd0)) ? -r_vy : r_vy;
    assign w_nx  = r_x + $signed({{6{r_vx[5]}}, r_vx});
    assign w_ny  = r_y + $signed({{6{w_vy1[5]}}, w_vy1});

    assign w_px     = $signed({1'b0, pixelX});
    assign w_py     = $signed({1'b0, pixelY});
    assign w_inside = (r_state != S_LOST) &&
                      (w_px >= r_x) && (w_px < r_x + SIZE_S) &&
                      (w_py >= r_y) && (w_py < r_y + SIZE_S);

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_vx_next    = r_vx;
        w_vy_next    = r_vy;
        w_cnt_next   = r_cnt;
        w_lost_next  = 1'b0;
        w_vy_eff     = w_vy1;
        w_vy_inc     = w_vy1 + 6'sd1;

        case (r_state)
            S_IDLE: begin
                if (startOfFrame && w_launch) begin
                    w_state_next = S_MOVING;
                    w_vx_next    = VX_INIT;
                    w_vy_next    = VY_INIT;
                    w_cnt_next   = '0;
                end
            end
            S_MOVING: begin
                if (startOfFrame) begin
                    if (w_ny >= Y_LIM) begin
                        // Exit through the bottom freezes the ball where it was last seen.
                        w_state_next = S_LOST;
                        w_lost_next  = 1'b1;
                    end else begin
                        if (w_nx <= 12'sd0) begin
                            w_x_next  = '0;
                            w_vx_next = -r_vx;
                        end else if (w_nx >= X_MAX) begin
                            w_x_next  = X_MAX;
                            w_vx_next = -r_vx;
                        end else begin
                            w_x_next = w_nx;
                        end

                        if (w_ny <= 12'sd0) begin
                            w_y_next = '0;
                            w_vy_eff = -w_vy1;
                        end else begin
                            w_y_next = w_ny;
                        end
                        w_vy_inc = w_vy_eff + 6'sd1;

                        if (r_cnt == CNT_LAST) begin
                            w_cnt_next = '0;
                            w_vy_next  = (w_vy_inc > V_MAX) ? V_MAX : w_vy_inc;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                            w_vy_next  = w_vy_eff;
                        end
                    end
                end
            end
            S_LOST: begin
                if (startOfFrame) begin
                    w_state_next = S_IDLE;
                    w_x_next     = X_INIT;
                    w_y_next     = Y_INIT;
                    w_vx_next    = VX_INIT;
                    w_vy_next    = VY_INIT;
                    w_cnt_next   = '0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= X_INIT;
            r_y        <= Y_INIT;
            r_vx       <= VX_INIT;
            r_vy       <= VY_INIT;
            r_cnt      <= '0;
            r_launch_l <= 1'b0;
            r_col_l    <= 1'b0;
            r_draw     <= 1'b0;
            r_rgb      <= 8'h00;
            r_lost     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_vx       <= w_vx_next;
            r_vy       <= w_vy_next;
            r_cnt      <= w_cnt_next;
            r_launch_l <= w_launch_l_next;
            r_col_l    <= w_col_l_next;
            r_draw     <= w_inside;
            r_rgb      <= w_inside ? BALL_COLOR : 8'h00;
            r_lost     <= w_lost_next;
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign ball_lost      = r_lost;
    assign topLeftX       = r_x[10:0];
    assign topLeftY       = r_y[10:0];

endmodule

// File: tb/tb_ball_object.sv
// Self-checking bench for ball_object: directed scenarios plus randomized play compared
// cycle by cycle against a frame-level physics model (default DUT and a GRAV_DIV=1 copy).
module tb_ball_object;

    localparam int ST_IDLE   = 0;
    localparam int ST_MOVING = 1;
    localparam int ST_LOST   = 2;

    typedef struct packed {
        int st;
        int x;
        int y;
        int vx;
        int vy;
        int cnt;
        bit ll;
        bit cl;
        bit draw;
        bit lost;
    } model_t;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, collision, launch;
    logic [10:0] pixelX, pixelY;
    logic        drawingRequest, ball_lost;
    logic [7:0]  RGBout;
    logic [10:0] topLeftX, topLeftY;
    logic        g1_dr, g1_lost;
    logic [7:0]  g1_rgb;
    logic [10:0] g1_tlx, g1_tly;

    int     n_checks = 0;
    int     n_fail   = 0;
    model_t m0, m1;

    always #5 clk = ~clk;

    ball_object dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .collision(collision), .launch(launch),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .ball_lost(ball_lost)
    );

    ball_object #(.GRAV_DIV(1)) dut_g1 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .collision(collision), .launch(launch),
        .drawingRequest(g1_dr), .RGBout(g1_rgb),
        .topLeftX(g1_tlx), .topLeftY(g1_tly), .ball_lost(g1_lost)
    );

    function automatic model_t reset_model();
        model_t r;
        r = '0;
        r.st = ST_IDLE; r.x = 320; r.y = 100; r.vx = 2; r.vy = 0;
        return r;
    endfunction

    // One clock of the ball as described by its frame rules.
    function automatic model_t model_step(model_t m, bit rst, bit sof, bit lch, bit col,
                                          int px, int py, int gdiv);
        model_t n;
        int vy1, nx, ny;
        bit lnow, cnow;
        if (rst) return reset_model();
        n = m;
        n.lost = 1'b0;
        n.draw = (m.st != ST_LOST) && px >= m.x && px < m.x + 16 && py >= m.y && py < m.y + 16;
        lnow = m.ll || (lch && m.st == ST_IDLE);
        cnow = m.cl || (col && m.st == ST_MOVING);
        n.ll = sof ? 1'b0 : lnow;
        n.cl = sof ? 1'b0 : cnow;
        if (!sof) return n;
        case (m.st)
            ST_IDLE: if (lnow) begin
                n.st = ST_MOVING; n.vx = 2; n.vy = 0; n.cnt = 0;
            end
            ST_MOVING: begin
                vy1 = (cnow && m.vy > 0) ? -m.vy : m.vy;
                nx  = m.x + m.vx;
                ny  = m.y + vy1;
                if (ny >= 480) begin
                    n.st = ST_LOST; n.lost = 1'b1;
                end else begin
                    if (nx <= 0) begin n.x = 0; n.vx = -m.vx; end
                    else if (nx >= 624) begin n.x = 624; n.vx = -m.vx; end
                    else n.x = nx;
                    if (ny <= 0) begin n.y = 0; vy1 = -vy1; end
                    else n.y = ny;
                    if (m.cnt == gdiv - 1) begin
                        n.cnt = 0;
                        n.vy  = (vy1 + 1 > 8) ? 8 : vy1 + 1;
                    end else begin
                        n.cnt = m.cnt + 1;
                        n.vy  = vy1;
                    end
                end
            end
            default: begin
                n.st = ST_IDLE; n.x = 320; n.y = 100; n.vx = 2; n.vy = 0; n.cnt = 0;
            end
        endcase
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        m0 = model_step(m0, reset, startOfFrame, launch, collision, int'(pixelX), int'(pixelY), 4);
        m1 = model_step(m1, reset, startOfFrame, launch, collision, int'(pixelX), int'(pixelY), 1);
        #1;
    endtask

    task automatic drive_idle();
        startOfFrame = 1'b0; launch = 1'b0; collision = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        pixelX = 11'd325; pixelY = 11'd105;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            startOfFrame = (i == 1); launch = (i == 1);
            tick();
            n_checks++;
            if ({drawingRequest, RGBout, ball_lost, topLeftX, topLeftY} !==
                {1'b0, 8'h00, 1'b0, 11'd320, 11'd100}) begin
                n_fail++;
                $display("FAIL reset_state got dr=%b rgb=%h lost=%b pos=(%0d,%0d) exp dr=0 rgb=00 lost=0 pos=(320,100)",
                         drawingRequest, RGBout, ball_lost, topLeftX, topLeftY);
            end
        end
        reset = 1'b0;
        drive_idle();
        tick();
        n_checks++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'hE0) begin
            n_fail++;
            $display("FAIL reset_draw got dr=%b rgb=%h exp dr=1 rgb=e0", drawingRequest, RGBout);
        end
    endtask

    task automatic sof_after_gap(input int gap, input bit chk_no_draw);
        drive_idle();
        for (int i = 0; i < gap; i++) begin
            tick();
            if (chk_no_draw) begin
                n_checks++;
                if (drawingRequest !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_draw_319 got dr=%b exp 0", drawingRequest);
                end
            end
        end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic test_launch_gravity();
        pixelX = 11'd319; pixelY = 11'd100;
        drive_idle();
        launch = 1'b1;
        tick();
        sof_after_gap(2, 1'b1);
        n_checks++;
        if (topLeftX !== 11'd320 || topLeftY !== 11'd100) begin
            n_fail++;
            $display("FAIL launch_sof_pos got (%0d,%0d) exp (320,100)", topLeftX, topLeftY);
        end
        for (int f = 0; f < 4; f++) sof_after_gap(3, 1'b1);
        n_checks++;
        if (topLeftX !== 11'd328 || topLeftY !== 11'd100) begin
            n_fail++;
            $display("FAIL gravity_4_pos got (%0d,%0d) exp (328,100)", topLeftX, topLeftY);
        end
        sof_after_gap(3, 1'b1);
        n_checks++;
        if (topLeftX !== 11'd330 || topLeftY !== 11'd101) begin
            n_fail++;
            $display("FAIL gravity_5_pos got (%0d,%0d) exp (330,101)", topLeftX, topLeftY);
        end
    endtask

    task automatic pick_pixel();
        int sel, bx, by, px, py;
        sel = int'($urandom_range(0, 3));
        if (sel == 3) begin
            pixelX = 11'($urandom_range(0, 700));
            pixelY = 11'($urandom_range(0, 520));
        end else begin
            bx = (sel == 0) ? m1.x : m0.x;
            by = (sel == 0) ? m1.y : m0.y;
            px = bx + int'($urandom_range(0, 20)) - 2;
            py = by + int'($urandom_range(0, 20)) - 2;
            pixelX = 11'((px < 0) ? 0 : px);
            pixelY = 11'((py < 0) ? 0 : py);
        end
    endtask

    task automatic test_random_play(input int frames, input bit keep_alive);
        logic [31:0] exp1, got1;
        for (int f = 0; f < frames; f++) begin
            int len;
            len = int'($urandom_range(3, 8));
            for (int c = 0; c < len; c++) begin
                startOfFrame = (c == len - 1);
                launch       = ($urandom_range(0, 3) == 0);
                if (keep_alive)
                    collision = (m0.y > 330 && m0.vy > 0 && $urandom_range(0, 1) == 1) ||
                                ($urandom_range(0, 15) == 0);
                else
                    collision = ($urandom_range(0, 15) == 0);
                pick_pixel();
                tick();
                n_checks++;
                if (topLeftX !== 11'(m0.x) || topLeftY !== 11'(m0.y)) begin
                    n_fail++;
                    $display("FAIL rand_pos got (%0d,%0d) exp (%0d,%0d)", topLeftX, topLeftY, m0.x, m0.y);
                end
                n_checks++;
                if (drawingRequest !== m0.draw || RGBout !== (m0.draw ? 8'hE0 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL rand_draw got dr=%b rgb=%h exp dr=%b", drawingRequest, RGBout, m0.draw);
                end
                n_checks++;
                if (ball_lost !== m0.lost) begin
                    n_fail++;
                    $display("FAIL rand_lost got %b exp %b", ball_lost, m0.lost);
                end
                exp1 = {11'(m1.x), 11'(m1.y), m1.draw, (m1.draw ? 8'hE0 : 8'h00), m1.lost};
                got1 = {g1_tlx, g1_tly, g1_dr, g1_rgb, g1_lost};
                n_checks++;
                if (got1 !== exp1) begin
                    n_fail++;
                    $display("FAIL rand_g1 got %h exp %h", got1, exp1);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_ball_lost();
        int lost_seen, frames;
        drive_idle();
        if (m0.st == ST_LOST) sof_after_gap(1, 1'b0);
        if (m0.st == ST_IDLE) begin
            launch = 1'b1; startOfFrame = 1'b1;
            tick();
            drive_idle();
        end
        lost_seen = 0;
        frames    = 0;
        while (m0.st != ST_LOST && frames < 300) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                lost_seen += int'(ball_lost);
            end
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            lost_seen += int'(ball_lost);
            frames++;
        end
        n_checks++;
        if (m0.st != ST_LOST) begin
            n_fail++;
            $display("FAIL lost_timeout got frames=%0d exp ball to leave bottom", frames);
        end
        pixelX = 11'(m0.x + 4);
        pixelY = 11'(m0.y + 4);
        for (int i = 0; i < 4; i++) begin
            launch = (i == 1);
            tick();
            lost_seen += int'(ball_lost);
            n_checks++;
            if (drawingRequest !== 1'b0 || RGBout !== 8'h00) begin
                n_fail++;
                $display("FAIL lost_no_draw got dr=%b rgb=%h exp dr=0 rgb=00", drawingRequest, RGBout);
            end
        end
        n_checks++;
        if (lost_seen != 1) begin
            n_fail++;
            $display("FAIL lost_pulse_width got %0d cycles exp 1", lost_seen);
        end
        for (int f = 0; f < 2; f++) begin
            sof_after_gap(2, 1'b0);
            n_checks++;
            if (topLeftX !== 11'd320 || topLeftY !== 11'd100) begin
                n_fail++;
                $display("FAIL lost_respawn_%0d got (%0d,%0d) exp (320,100)", f, topLeftX, topLeftY);
            end
        end
    endtask

    task automatic test_launch_with_sof();
        drive_idle();
        launch = 1'b1; startOfFrame = 1'b1;
        tick();
        drive_idle();
        n_checks++;
        if (topLeftX !== 11'd320 || topLeftY !== 11'd100) begin
            n_fail++;
            $display("FAIL launch_with_sof_pos got (%0d,%0d) exp (320,100)", topLeftX, topLeftY);
        end
        sof_after_gap(3, 1'b0);
        n_checks++;
        if (topLeftX !== 11'd322 || topLeftY !== 11'd100) begin
            n_fail++;
            $display("FAIL launch_with_sof_move got (%0d,%0d) exp (322,100)", topLeftX, topLeftY);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        pixelX = '0; pixelY = '0;
        m0 = reset_model();
        m1 = reset_model();
        test_reset();
        test_launch_gravity();
        test_random_play(300, 1'b1);
        test_ball_lost();
        test_launch_with_sof();
        test_random_play(250, 1'b0);
        test_reset();
        test_random_play(40, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
